// File: rtl/nn_pkg.sv
// Shared definitions for the classification-stage blocks: state encoding,
// default compare mode and a constant-evaluable ceil(log2) helper.
package nn_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t SCAN = 1'b1;

    // Default comparison mode: two's-complement fixed-point neuron outputs.
    localparam bit ARGMAX_SIGNED = 1'b1;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (longint unsigned v = 1; v < longint'(n); v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/argmax_cmp.sv
// Combinational strict greater-than over W bits, signed or unsigned.
// Kept separate so later top-k stages can share the same comparator.
module argmax_cmp #(
    parameter int unsigned W      = 16,
    parameter bit          SIGNED = 1'b1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic         gt_o
);

    generate
        if (SIGNED) begin : g_signed
            assign gt_o = $signed(a_i) > $signed(b_i);
        end else begin : g_unsigned
            assign gt_o = a_i > b_i;
        end
    endgenerate

endmodule

// File: rtl/layer_argmax.sv
// Final classification stage: captures a full layer output, then scans it one
// element per cycle with a single comparator to find the index/value of the max.
module layer_argmax
    import nn_pkg::*;
#(
    parameter int unsigned NN        = 10,
    parameter int unsigned dataWidth = 16,
    parameter bit          SIGNED    = ARGMAX_SIGNED,
    parameter int unsigned IDX_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_valid,
    input  logic [NN*dataWidth-1:0] i_data,
    output logic                    o_valid,
    output logic [IDX_W-1:0]        o_index,
    output logic [dataWidth-1:0]    o_max,
    output logic                    o_busy,
    output logic                    o_drop
);

    localparam int unsigned CNT_W = (clog2(NN) < 1) ? 1 : clog2(NN);

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [dataWidth-1:0]   max_q, max_d;
    logic                   valid_q, valid_d;
    logic [IDX_W-1:0]       index_q, index_d;
    logic [dataWidth-1:0]   omax_q, omax_d;
    logic                   busy_q, busy_d;
    logic                   drop_q, drop_d;

    logic [dataWidth-1:0]   buf_q [NN];
    logic                   load;
    logic [dataWidth-1:0]   cand;
    logic                   gt;
    logic                   last;

    assign cand = buf_q[cnt_q];
    assign last = (cnt_q == CNT_W'(NN - 1));

    argmax_cmp #(
        .W      (dataWidth),
        .SIGNED (SIGNED)
    ) u_cmp (
        .a_i  (cand),
        .b_i  (max_q),
        .gt_o (gt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        max_d   = max_q;
        valid_d = 1'b0;
        index_d = index_q;
        omax_d  = omax_q;
        busy_d  = busy_q;
        drop_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    load = 1'b1;
                    if (NN == 1) begin
                        // Single class: the only element is the answer.
                        valid_d = 1'b1;
                        index_d = '0;
                        omax_d  = i_data[dataWidth-1:0];
                    end else begin
                        max_d   = i_data[dataWidth-1:0];
                        idx_d   = '0;
                        cnt_d   = CNT_W'(1);
                        busy_d  = 1'b1;
                        state_d = SCAN;
                    end
                end
            end
            SCAN: begin
                if (i_valid) begin
                    drop_d = 1'b1;
                end
                // Strict greater-than keeps the lower index on ties.
                if (gt) begin
                    max_d = cand;
                    idx_d = cnt_q;
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    valid_d = 1'b1;
                    index_d = gt ? IDX_W'(cnt_q) : IDX_W'(idx_q);
                    omax_d  = gt ? cand : max_q;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            max_q   <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            omax_q  <= '0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            max_q   <= max_d;
            valid_q <= valid_d;
            index_q <= index_d;
            omax_q  <= omax_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (load) begin
            for (int unsigned k = 0; k < NN; k++) begin
                buf_q[k] <= i_data[k*dataWidth +: dataWidth];
            end
        end
    end

    assign o_valid = valid_q;
    assign o_index = index_q;
    assign o_max   = omax_q;
    assign o_busy  = busy_q;
    assign o_drop  = drop_q;

endmodule

// File: tb/tb_layer_argmax.sv
// Scoreboard bench for layer_argmax: signed and unsigned NN=10 builds share one
// stimulus stream; an NN=1 build is driven separately.
module tb_layer_argmax;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_valid = 1'b0;
    logic [159:0]  i_data = '0;
    logic          v1_valid = 1'b0;
    logic [15:0]   v1_data = '0;

    logic          s_valid, s_busy, s_drop;
    logic [31:0]   s_index;
    logic [15:0]   s_max;
    logic          u_valid, u_busy, u_drop;
    logic [31:0]   u_index;
    logic [15:0]   u_max;
    logic          o1_valid, o1_busy, o1_drop;
    logic [31:0]   o1_index;
    logic [15:0]   o1_max;

    always #5 clk = ~clk;

    layer_argmax #(.NN(10), .dataWidth(16), .SIGNED(1'b1), .IDX_W(32)) dut_s (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(s_valid), .o_index(s_index), .o_max(s_max),
        .o_busy(s_busy), .o_drop(s_drop)
    );

    layer_argmax #(.NN(10), .dataWidth(16), .SIGNED(1'b0), .IDX_W(32)) dut_u (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(u_valid), .o_index(u_index), .o_max(u_max),
        .o_busy(u_busy), .o_drop(u_drop)
    );

    layer_argmax #(.NN(1), .dataWidth(16), .SIGNED(1'b1), .IDX_W(32)) dut_1 (
        .clk(clk), .rst(rst), .i_valid(v1_valid), .i_data(v1_data),
        .o_valid(o1_valid), .o_index(o1_index), .o_max(o1_max),
        .o_busy(o1_busy), .o_drop(o1_drop)
    );

    typedef struct {
        logic [31:0] idx;
        logic [15:0] mx;
        longint      cyc;
    } exp_t;

    typedef struct {
        int          kind;
        logic [63:0] exp;
        string       name;
    } probe_t;

    exp_t   sb_s[$];
    exp_t   sb_u[$];
    exp_t   sb_1[$];
    probe_t pq[$];

    longint cyc = 0;
    int     total = 0;
    int     bad = 0;
    int     drops_s = 0;
    int     drops_u = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] st(input logic v, input logic b, input logic d,
                                       input logic [31:0] i, input logic [15:0] m);
        return {13'd0, v, b, d, i, m};
    endfunction

    function automatic logic [159:0] mk(input logic [15:0] e0, input logic [15:0] e1,
                                        input logic [15:0] e2, input logic [15:0] e3,
                                        input logic [15:0] e4, input logic [15:0] e5,
                                        input logic [15:0] e6, input logic [15:0] e7,
                                        input logic [15:0] e8, input logic [15:0] e9);
        return {e9, e8, e7, e6, e5, e4, e3, e2, e1, e0};
    endfunction

    // ---------------- monitor: all comparisons happen here ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t   e;
        probe_t p;
        if (s_valid) begin
            if (sb_s.size() == 0) begin
                chk("s_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb_s.pop_front();
                chk("s_index", 64'(s_index), 64'(e.idx));
                chk("s_max", 64'(s_max), 64'(e.mx));
                chk("s_latency", 64'(cyc), 64'(e.cyc));
                chk("s_busy_at_valid", 64'(s_busy), 64'd0);
            end
        end
        if (u_valid) begin
            if (sb_u.size() == 0) begin
                chk("u_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb_u.pop_front();
                chk("u_index", 64'(u_index), 64'(e.idx));
                chk("u_max", 64'(u_max), 64'(e.mx));
                chk("u_latency", 64'(cyc), 64'(e.cyc));
                chk("u_busy_at_valid", 64'(u_busy), 64'd0);
            end
        end
        if (o1_valid) begin
            if (sb_1.size() == 0) begin
                chk("nn1_unexpected_valid", 64'd1, 64'd0);
            end else begin
                e = sb_1.pop_front();
                chk("nn1_index", 64'(o1_index), 64'(e.idx));
                chk("nn1_max", 64'(o1_max), 64'(e.mx));
                chk("nn1_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        if (s_drop) drops_s++;
        if (u_drop) drops_u++;
        while (pq.size() > 0) begin
            p = pq.pop_front();
            case (p.kind)
                0: chk(p.name, st(s_valid, s_busy, s_drop, s_index, s_max), p.exp);
                1: chk(p.name, st(u_valid, u_busy, u_drop, u_index, u_max), p.exp);
                2: chk(p.name, st(o1_valid, o1_busy, o1_drop, o1_index, o1_max), p.exp);
                3: chk(p.name, 64'(drops_s), p.exp);
                4: chk(p.name, 64'(drops_u), p.exp);
                5: chk(p.name, 64'(sb_s.size() + sb_u.size() + sb_1.size()), p.exp);
                default: ;
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic probe(input int kind, input logic [63:0] expv, input string name);
        probe_t p;
        p.kind = kind;
        p.exp  = expv;
        p.name = name;
        pq.push_back(p);
    endtask

    // Present one layer output for a single cycle; when accepted, queue the
    // hand-computed signed and unsigned answers due NN=10 cycles later.
    task automatic drive(input logic [159:0] v, input bit acc,
                         input logic [31:0] si, input logic [15:0] sm,
                         input logic [31:0] ui, input logic [15:0] um);
        exp_t e;
        i_valid = 1'b1;
        i_data  = v;
        if (acc) begin
            e.cyc = cyc + 10;
            e.idx = si; e.mx = sm; sb_s.push_back(e);
            e.idx = ui; e.mx = um; sb_u.push_back(e);
        end
        tick(1);
        i_valid = 1'b0;
    endtask

    task automatic drive1(input logic [15:0] v);
        exp_t e;
        v1_valid = 1'b1;
        v1_data  = v;
        e.cyc = cyc + 1;
        e.idx = 32'd0;
        e.mx  = v;
        sb_1.push_back(e);
    endtask

    logic [159:0] v1, v2, v3, v4, v5, v6;

    initial begin
        v1 = mk(16'h0500, 16'h0300, 16'h0900, 16'h0100, 16'h0000,
                16'h0200, 16'h0800, 16'h0700, 16'h0400, 16'h0600);
        v2 = mk(16'hFB00, 16'hFF00, 16'hF900, 16'hFD00, 16'hFE00,
                16'hF800, 16'hFC00, 16'hFA00, 16'hF700, 16'hF600);
        v3 = mk(16'h0100, 16'h0200, 16'h0000, 16'h0400, 16'h0300,
                16'h0100, 16'h0200, 16'h0400, 16'h0000, 16'h0300);
        v4 = mk(16'h0100, 16'hFF00, 16'h0300, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0200);
        v5 = mk(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                16'h0600, 16'h0700, 16'h0800, 16'h0900, 16'h7F00);
        v6 = mk(16'h7FFF, 16'h0100, 16'h0000, 16'h8000, 16'h0200,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

        rst = 1'b1;
        tick(3);
        probe(0, st(0, 0, 0, 32'd0, 16'h0000), "s_reset_state");
        probe(1, st(0, 0, 0, 32'd0, 16'h0000), "u_reset_state");
        probe(2, st(0, 0, 0, 32'd0, 16'h0000), "nn1_reset_state");
        rst = 1'b0;
        tick(1);

        // Ascending-unsorted Q8.8 data, then a dropped input 4 cycles into
        // the scan, then a new input in the o_valid cycle.
        drive(v1, 1'b1, 32'd2, 16'h0900, 32'd2, 16'h0900);
        tick(2);
        probe(0, st(0, 1, 0, 32'd0, 16'h0000), "s_busy_midscan");
        tick(1);
        drive(v3, 1'b0, 32'd0, 16'h0, 32'd0, 16'h0);
        probe(0, st(0, 1, 1, 32'd0, 16'h0000), "s_drop_pulse");
        tick(5);
        probe(0, st(1, 0, 0, 32'd2, 16'h0900), "s_result_cycle");
        probe(1, st(1, 0, 0, 32'd2, 16'h0900), "u_result_cycle");
        drive(v4, 1'b1, 32'd2, 16'h0300, 32'd1, 16'hFF00);
        tick(1);
        probe(0, st(0, 1, 0, 32'd2, 16'h0900), "s_hold_after_valid");
        tick(10);
        probe(3, 64'd1, "s_drop_count");
        probe(4, 64'd1, "u_drop_count");

        // Sustained throughput: inputs exactly NN cycles apart.
        drive(v2, 1'b1, 32'd1, 16'hFF00, 32'd1, 16'hFF00);
        tick(9);
        drive(v3, 1'b1, 32'd3, 16'h0400, 32'd3, 16'h0400);
        tick(9);
        drive(v5, 1'b1, 32'd9, 16'h7F00, 32'd9, 16'h7F00);
        tick(11);
        drive(v6, 1'b1, 32'd0, 16'h7FFF, 32'd3, 16'h8000);
        tick(11);
        probe(3, 64'd1, "s_drop_count_final");

        // Reset during scan cycle 5 aborts the scan with no result.
        drive(v2, 1'b1, 32'd1, 16'hFF00, 32'd1, 16'hFF00);
        tick(4);
        rst = 1'b1;
        sb_s.delete();
        sb_u.delete();
        tick(1);
        rst = 1'b0;
        probe(0, st(0, 0, 0, 32'd0, 16'h0000), "s_after_abort");
        probe(1, st(0, 0, 0, 32'd0, 16'h0000), "u_after_abort");
        tick(15);
        drive(v4, 1'b1, 32'd2, 16'h0300, 32'd1, 16'hFF00);
        tick(11);

        // NN=1 build: result one cycle later, back-to-back inputs accepted.
        drive1(16'h1234);
        tick(1);
        drive1(16'h8001);
        tick(1);
        v1_valid = 1'b0;
        tick(1);
        probe(2, st(0, 0, 0, 32'd0, 16'h8001), "nn1_hold");

        for (int k = 0; k < 40 && (sb_s.size() + sb_u.size() + sb_1.size()) > 0; k++) begin
            tick(1);
        end
        probe(5, 64'd0, "scoreboard_drained");
        tick(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/layer_argmax.md
Name: layer_argmax

Overview:
- Final classification stage. Sits directly downstream of the last fully-connected layer and consumes its parallel neuron output bus.
- Captures all NN neuron outputs in one cycle, then scans them sequentially, one compare per cycle.
- Reports the index and value of the largest output as the network's predicted class.
- The sequential scan keeps a single comparator, avoiding an NN-wide combinational tree.

Parameters:
- NN, 10, number of neurons/classes in the consumed layer (>=1)
- dataWidth, 16, bit width of each neuron output
- SIGNED, 1, 1 = compare as two's-complement fixed-point; 0 = compare as unsigned
- IDX_W, 32, width of the index output; must be >= clog2(NN)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_valid  in  1  layer output valid; top level connects the layer's o_valid[0], since all neurons assert together
- i_data  in  NN*dataWidth  neuron outputs; element k at [k*dataWidth +: dataWidth]
- o_valid  out  1  one-cycle pulse; o_index and o_max are valid while high
- o_index  out  IDX_W  index of maximum element, zero-extended
- o_max  out  dataWidth  value of maximum element
- o_busy  out  1  high while a scan is in progress
- o_drop  out  1  one-cycle pulse when i_valid arrives while busy

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: o_valid=0, o_index=0, o_max=0, o_busy=0, o_drop=0, state=IDLE, scan counter=0. Buffer contents are don't-care.
- States: IDLE, SCAN.
- IDLE:
  - On i_valid, register the full i_data into the buffer.
  - Load max=element 0, idx=0, counter=1, o_busy=1, go to SCAN.
  - If NN==1, skip SCAN: pulse o_valid next cycle with idx 0 and stay in IDLE.
- SCAN, one element per cycle:
  - Compare buffer[counter] against max using strict greater-than (signed if SIGNED=1). If greater, update max and idx.
  - Ties keep the lower index.
  - counter increments each cycle.
  - After comparing element NN-1: register the final idx/max to o_index/o_max, pulse o_valid for one cycle, clear o_busy, return to IDLE on the same edge.
- Latency: i_valid sampled at edge E; o_valid is high in the cycle following edge E+(NN-1). For NN=10, that is 10 cycles after the input cycle.
- o_index and o_max hold their last values after o_valid drops, until the next result.
- Back-to-back:
  - i_valid in the same cycle o_valid is high is accepted, because the state is already IDLE.
  - Sustained throughput: one result per NN cycles.
- i_valid while in SCAN: input ignored, buffer untouched, o_drop pulses for one cycle, scan continues unaffected.
- rst asserted mid-scan: scan aborted, no o_valid, all outputs return to reset values on the next edge.
- Width rule: comparison is on the full dataWidth; no saturation or truncation. idx zero-extends into IDX_W.

Decomposition:
- Shared package nn_pkg holds:
  - a clog2 function
  - a state encoding typedef (IDLE/SCAN)
  - a compare-mode constant mirroring SIGNED
- The counter width localparam clog2(NN) lives in the block.
- One natural sub-module: argmax_cmp, a combinational greater-than over dataWidth honouring SIGNED. It is reused by any future top-k stage.

Test Plan:
- NN=10, SIGNED=1, elements 0..9 = {5,3,9,1,0,2,8,7,4,6} (each ×256, Q8.8), one i_valid pulse -> after 10 cycles o_valid=1 for exactly 1 cycle, o_index=2, o_max=16'h0900, o_busy low the same cycle.
- All negative values {-5,-1,-7,...} (-1 at index 1) with SIGNED=1 -> o_index=1, o_max=16'hFF00. Same data with SIGNED=0 -> o_index is that of the largest unsigned pattern (index 1, 16'hFF00, if it is the largest code).
- Ties: elements 3 and 7 both 16'h0400 and maximal -> o_index=3.
- Second i_valid 4 cycles into a scan with different data -> o_drop pulses once, first result unchanged. Then i_valid in the o_valid cycle -> accepted, second o_valid exactly 10 cycles later.
- rst pulsed at scan cycle 5 -> no o_valid, o_busy=0, o_index=0 next cycle. A fresh input afterwards yields a correct result.
- NN=1 build: i_valid with 16'h1234 -> o_valid the next cycle, o_index=0, o_max=16'h1234.
